// File: rtl/traffic_lights.sv
// Fixed-time four-road intersection controller: each road in turn gets
// green, yellow, then an all-red clearance before the next road is served.
module traffic_lights #(
  parameter int GREEN_TIME   = 8,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1
) (
  input  logic clk,
  input  logic reset,
  output logic R1_L_red, output logic R1_L_yellow, output logic R1_L_green,
  output logic R1_S_red, output logic R1_S_yellow, output logic R1_S_green,
  output logic R1_R_red, output logic R1_R_yellow, output logic R1_R_green,
  output logic R2_L_red, output logic R2_L_yellow, output logic R2_L_green,
  output logic R2_S_red, output logic R2_S_yellow, output logic R2_S_green,
  output logic R2_R_red, output logic R2_R_yellow, output logic R2_R_green,
  output logic R3_L_red, output logic R3_L_yellow, output logic R3_L_green,
  output logic R3_S_red, output logic R3_S_yellow, output logic R3_S_green,
  output logic R3_R_red, output logic R3_R_yellow, output logic R3_R_green,
  output logic R4_L_red, output logic R4_L_yellow, output logic R4_L_green,
  output logic R4_S_red, output logic R4_S_yellow, output logic R4_S_green,
  output logic R4_R_red, output logic R4_R_yellow, output logic R4_R_green
);

  // State is {road, phase}; phase 2'b11 is unused and recovers to AR4.
  localparam logic [1:0] PH_G  = 2'd0;
  localparam logic [1:0] PH_Y  = 2'd1;
  localparam logic [1:0] PH_AR = 2'd2;
  localparam logic [1:0] ROAD4 = 2'd3;

  localparam logic [7:0] G_LAST  = 8'(GREEN_TIME - 1);
  localparam logic [7:0] Y_LAST  = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_LAST = 8'(ALL_RED_TIME - 1);

  logic [1:0] r_road;
  logic [1:0] r_phase;
  logic [7:0] r_cnt;

  logic [1:0] w_road_next;
  logic [1:0] w_phase_next;
  logic [7:0] w_cnt_next;

  logic [3:0] w_red;
  logic [3:0] w_yel;
  logic [3:0] w_grn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_road  <= ROAD4;
      r_phase <= PH_AR;
      r_cnt   <= 8'd0;
    end else begin
      r_road  <= w_road_next;
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_road_next  = r_road;
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt + 8'd1;
    case (r_phase)
      PH_G: begin
        if (r_cnt == G_LAST) begin
          w_phase_next = PH_Y;
          w_cnt_next   = 8'd0;
        end
      end
      PH_Y: begin
        if (r_cnt == Y_LAST) begin
          w_phase_next = PH_AR;
          w_cnt_next   = 8'd0;
        end
      end
      PH_AR: begin
        // Clearance done: hand over to the next road, wrapping R4 -> R1.
        if (r_cnt == AR_LAST) begin
          w_road_next  = r_road + 2'd1;
          w_phase_next = PH_G;
          w_cnt_next   = 8'd0;
        end
      end
      default: begin
        w_road_next  = ROAD4;
        w_phase_next = PH_AR;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_red = 4'b1111;
    w_yel = 4'b0000;
    w_grn = 4'b0000;
    if (r_phase == PH_G) begin
      w_red[r_road] = 1'b0;
      w_grn[r_road] = 1'b1;
    end else if (r_phase == PH_Y) begin
      w_red[r_road] = 1'b0;
      w_yel[r_road] = 1'b1;
    end
  end

  assign R1_L_red = w_red[0]; assign R1_L_yellow = w_yel[0]; assign R1_L_green = w_grn[0];
  assign R1_S_red = w_red[0]; assign R1_S_yellow = w_yel[0]; assign R1_S_green = w_grn[0];
  assign R1_R_red = w_red[0]; assign R1_R_yellow = w_yel[0]; assign R1_R_green = w_grn[0];
  assign R2_L_red = w_red[1]; assign R2_L_yellow = w_yel[1]; assign R2_L_green = w_grn[1];
  assign R2_S_red = w_red[1]; assign R2_S_yellow = w_yel[1]; assign R2_S_green = w_grn[1];
  assign R2_R_red = w_red[1]; assign R2_R_yellow = w_yel[1]; assign R2_R_green = w_grn[1];
  assign R3_L_red = w_red[2]; assign R3_L_yellow = w_yel[2]; assign R3_L_green = w_grn[2];
  assign R3_S_red = w_red[2]; assign R3_S_yellow = w_yel[2]; assign R3_S_green = w_grn[2];
  assign R3_R_red = w_red[2]; assign R3_R_yellow = w_yel[2]; assign R3_R_green = w_grn[2];
  assign R4_L_red = w_red[3]; assign R4_L_yellow = w_yel[3]; assign R4_L_green = w_grn[3];
  assign R4_S_red = w_red[3]; assign R4_S_yellow = w_yel[3]; assign R4_S_green = w_grn[3];
  assign R4_R_red = w_red[3]; assign R4_R_yellow = w_yel[3]; assign R4_R_green = w_grn[3];

endmodule

// File: tb/tb_traffic_lights.sv
// Bench for traffic_lights: default instance plus a short-timing instance,
// directed edge-by-edge lamp checks and a continuous safety monitor.
`timescale 1ns/1ps
module tb_traffic_lights;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Lamp vector bit = road*9 + movement*3 + colour (0 red, 1 yellow, 2 green).
  wire [35:0] a_lamps;
  wire [35:0] b_lamps;

`define LAMP_PORTS(v) \
    .R1_L_red(v[0]),  .R1_L_yellow(v[1]),  .R1_L_green(v[2]), \
    .R1_S_red(v[3]),  .R1_S_yellow(v[4]),  .R1_S_green(v[5]), \
    .R1_R_red(v[6]),  .R1_R_yellow(v[7]),  .R1_R_green(v[8]), \
    .R2_L_red(v[9]),  .R2_L_yellow(v[10]), .R2_L_green(v[11]), \
    .R2_S_red(v[12]), .R2_S_yellow(v[13]), .R2_S_green(v[14]), \
    .R2_R_red(v[15]), .R2_R_yellow(v[16]), .R2_R_green(v[17]), \
    .R3_L_red(v[18]), .R3_L_yellow(v[19]), .R3_L_green(v[20]), \
    .R3_S_red(v[21]), .R3_S_yellow(v[22]), .R3_S_green(v[23]), \
    .R3_R_red(v[24]), .R3_R_yellow(v[25]), .R3_R_green(v[26]), \
    .R4_L_red(v[27]), .R4_L_yellow(v[28]), .R4_L_green(v[29]), \
    .R4_S_red(v[30]), .R4_S_yellow(v[31]), .R4_S_green(v[32]), \
    .R4_R_red(v[33]), .R4_R_yellow(v[34]), .R4_R_green(v[35])

  traffic_lights dut_a (
    .clk(clk),
    .reset(reset),
    `LAMP_PORTS(a_lamps)
  );

  traffic_lights #(.GREEN_TIME(2), .YELLOW_TIME(1), .ALL_RED_TIME(2)) dut_b (
    .clk(clk),
    .reset(reset),
    `LAMP_PORTS(b_lamps)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  // road < 0 means every road red; col: 0 red, 1 yellow, 2 green.
  function automatic logic [35:0] pat(int road, int col);
    logic [35:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int m = 0; m < 3; m++)
        if (r == road) v[r*9 + m*3 + col] = 1'b1;
        else           v[r*9 + m*3]       = 1'b1;
    return v;
  endfunction

  // Defaults: per road 8 green, 3 yellow, 1 all-red; edge 1 is first R1 green.
  function automatic logic [35:0] exp_a(int n);
    int q, p;
    if (n < 1) return pat(-1, 0);
    q = (n - 1) % 48;
    p = q % 12;
    if (p < 8)  return pat(q / 12, 2);
    if (p < 11) return pat(q / 12, 1);
    return pat(-1, 0);
  endfunction

  // Override 2/1/2: edge 1 still in AR4, R1 green from edge 2, 20-cycle period.
  function automatic logic [35:0] exp_b(int n);
    int q, p;
    if (n < 2) return pat(-1, 0);
    q = (n - 2) % 20;
    p = q % 5;
    if (p < 2)  return pat(q / 5, 2);
    if (p == 2) return pat(q / 5, 1);
    return pat(-1, 0);
  endfunction

  task automatic check(string tag, logic [35:0] got, logic [35:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int count_viol(logic [35:0] cur, logic [35:0] prev);
    int v, nonred;
    logic [2:0] m0, mv, pv;
    v = 0;
    nonred = 0;
    for (int r = 0; r < 4; r++) begin
      m0 = cur[r*9 +: 3];
      pv = prev[r*9 +: 3];
      for (int m = 0; m < 3; m++) begin
        mv = cur[r*9 + m*3 +: 3];
        if (!(mv == 3'b001 || mv == 3'b010 || mv == 3'b100)) v++;
        if (mv != m0) v++;
      end
      if (m0 != 3'b001) nonred++;
      if (pv == 3'b100 && !(m0 == 3'b100 || m0 == 3'b010)) v++;
    end
    if (nonred > 1) v++;
    return v;
  endfunction

  logic [35:0] a_prev;
  logic [35:0] b_prev;

  always @(negedge clk) begin
    if (reset) begin
      a_prev = pat(-1, 0);
      b_prev = pat(-1, 0);
    end else begin
      viol = viol + count_viol(a_lamps, a_prev) + count_viol(b_lamps, b_prev);
      a_prev = a_lamps;
      b_prev = b_lamps;
    end
  end

  task automatic run_edges(int count, string phase);
    for (int n = 1; n <= count; n++) begin
      tick();
      check($sformatf("%s_a_edge%0d", phase, n), a_lamps, exp_a(n));
      check($sformatf("%s_b_edge%0d", phase, n), b_lamps, exp_b(n));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_a_%0d", i), a_lamps, pat(-1, 0));
      check($sformatf("reset_b_%0d", i), b_lamps, pat(-1, 0));
    end
    reset = 1'b0;

    // Full period plus wrap, then on into R3 green (edge 75).
    run_edges(75, "run");

    reset = 1'b1;
    tick();
    check("midreset_a", a_lamps, pat(-1, 0));
    check("midreset_b", b_lamps, pat(-1, 0));
    reset = 1'b0;

    // Restart must begin again at R1, not resume R3.
    run_edges(14, "restart");

    tick();
    check("invariants", 36'(viol), 36'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_lights.md
Name: traffic_lights

Overview:
- Fixed-time controller for a four-road intersection (R1..R4).
- Each road has three movements: Left (L), Straight (S), Right (R). Each movement drives a red/yellow/green lamp triple.
- Roads are served round-robin, one road at a time: green, then yellow, then an all-red clearance before the next road.
- Standalone top-level lamp driver; no sensor inputs.

Parameters:
- GREEN_TIME, 8, cycles a road holds green (1..255)
- YELLOW_TIME, 3, cycles a road holds yellow (1..255)
- ALL_RED_TIME, 1, cycles of all-red clearance between roads (1..255)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- R1_L_red, R1_L_yellow, R1_L_green  output  1 each  road 1 left-turn lamps
- R1_S_red, R1_S_yellow, R1_S_green  output  1 each  road 1 straight lamps
- R1_R_red, R1_R_yellow, R1_R_green  output  1 each  road 1 right-turn lamps
- R2_*, R3_*, R4_* {L,S,R}_{red,yellow,green}  output  1 each  same pattern for roads 2, 3 and 4 (36 lamp outputs total)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- States, in cycle order: G1, Y1, AR1, G2, Y2, AR2, G3, Y3, AR3, G4, Y4, AR4, then back to G1.
- State and timer registers:
  - 8-bit dwell counter, cnt, cleared on every state change.
  - In G states: when cnt == GREEN_TIME-1, advance at the next edge; otherwise cnt+1.
  - Y states use the same rule with YELLOW_TIME; AR states use ALL_RED_TIME.
  - Each state therefore lasts exactly its parameter value in cycles.
- Reset:
  - At a rising edge with reset=1: state <= AR4, cnt <= 0.
  - All 36 outputs show red from that edge onward.
  - Reset asserted mid-operation overrides any pending transition and has the same effect.
  - While reset is held, state stays AR4 with cnt 0.
- After reset release: first edge with reset=0 begins counting in AR4. With ALL_RED_TIME=1, R1 goes green after that first edge.
- Output decode: Moore, combinational from the state register only. No combinational path from reset to outputs.
  - Gk: all three movements of road k green=1, yellow=0, red=0.
  - Yk: road k yellow=1, red=0, green=0.
  - All other roads in Gk/Yk, and every road in any AR state: red=1, yellow=0, green=0.
- Invariants, checked every cycle outside reset:
  - Each movement has exactly one lamp lit.
  - At most one road is non-red.
  - The three movements of a road are always identical.
  - Green is always followed by yellow, never by red directly.
  - No two roads are green or yellow simultaneously.
- Cycle period = 4*(GREEN_TIME+YELLOW_TIME+ALL_RED_TIME), which is 48 cycles at defaults.
- An illegal or unused state encoding recovers to AR4 with cnt=0 at the next edge.

Test Plan:
1. Reset behaviour: hold reset=1 for 1 edge, then release -> all 36 lamps red. At defaults, first release edge -> R1 L/S/R green=1; R2..R4 red.
2. Phase timing (defaults, edge n counted from release): R1 green for edges 1..8; R1 yellow for edges 9..11; all red at edge 12; R2 green for edges 13..20; R4 yellow for edges 45..47; all red at edge 48; R1 green again at edge 49.
3. Invariant monitor over 1000 ns (10 ns clock): one-hot lamps per movement; never more than one road non-red; movements within a road identical -> zero violations.
4. Mid-cycle reset: assert reset for one edge while R3 is green -> next edge all red, cnt=0. After release, sequence restarts at R1 green per scenario 2; R3 does not resume.
5. Parameter override GREEN_TIME=2, YELLOW_TIME=1, ALL_RED_TIME=2 -> R1 green edges 2..3, yellow edge 4, all red edges 5..6, R2 green edge 7; period 20 cycles.
